// File: rtl/mips_pkg.sv
// mips_pkg: constants shared by the MIPS core front end.
//   RESET_PC_C / ILLOP_PC_C / XADR_PC_C : reset, interrupt and exception vectors
//   NOP_INSTR                           : all-zero word (sll $0,$0,0), used for bubbles
//   KERNEL_BIT                          : PC bit holding the supervisor flag
//   pc_plus4()                          : sequential PC that keeps the kernel bit
package mips_pkg;
  localparam logic [31:0] RESET_PC_C = 32'h8000_0000;
  localparam logic [31:0] ILLOP_PC_C = 32'h8000_0004;
  localparam logic [31:0] XADR_PC_C  = 32'h8000_0008;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
  localparam int          KERNEL_BIT = 31;

  // The low 31 bits wrap on their own, so user code can never carry into kernel mode.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return {pc[KERNEL_BIT], pc[30:0] + 31'd4};
  endfunction
endpackage

// File: rtl/fetch_pc_sel.sv
// fetch_pc_sel: combinational next-PC priority mux for the fetch stage.
//   in : pc_q, exc/irq/redirect/stall/flush events, redirect target, rom overflow
//   out: next_pc, ifid_bubble (squash IF/ID), ifid_hold (keep IF/ID),
//        vector_taken (exception/interrupt vector entered this cycle)
// Macro FETCH_OVF_EXC_EN: rom_ovf_i becomes a fetch exception.
module fetch_pc_sel
  import mips_pkg::*;
#(
  parameter logic [31:0] ILLOP_PC = ILLOP_PC_C,
  parameter logic [31:0] XADR_PC  = XADR_PC_C
) (
  input  logic [31:0] pc_q,
  input  logic        exc_i,
  input  logic        irq_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        rom_ovf_i,
  output logic [31:0] next_pc,
  output logic        ifid_bubble,
  output logic        ifid_hold,
  output logic        vector_taken
);
  logic kernel;
  assign kernel = pc_q[KERNEL_BIT];

  // Branch targets are word aligned; the two low bits carry no information.
  logic [1:0] unused_rpc_lo;
  assign unused_rpc_lo = redirect_pc_i[1:0];

`ifdef FETCH_OVF_EXC_EN
  logic fetch_exc;
  assign fetch_exc = rom_ovf_i;
`else
  logic fetch_exc;
  logic unused_ovf;
  assign fetch_exc  = 1'b0;
  assign unused_ovf = rom_ovf_i;
`endif

  always_comb begin
    next_pc      = pc_plus4(pc_q);
    ifid_bubble  = flush_i;
    ifid_hold    = 1'b0;
    vector_taken = 1'b0;
    if (exc_i) begin
      next_pc      = XADR_PC;
      ifid_bubble  = 1'b1;
      vector_taken = 1'b1;
    end else if (fetch_exc) begin
      // A bad fetch inside the handler would loop on the vector; park instead.
      ifid_bubble = 1'b1;
      if (kernel) begin
        next_pc = pc_q;
      end else begin
        next_pc      = XADR_PC;
        vector_taken = 1'b1;
      end
    end else if (irq_i && !kernel) begin
      next_pc      = ILLOP_PC;
      ifid_bubble  = 1'b1;
      vector_taken = 1'b1;
    end else if (redirect_i) begin
      next_pc     = {redirect_pc_i[31:2], 2'b00};
      ifid_bubble = 1'b1;
    end else if (stall_i) begin
      next_pc   = pc_q;
      ifid_hold = !flush_i;
    end
  end
endmodule

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: MIPS instruction-fetch stage. Owns the PC, addresses the
// combinational instruction ROM and registers the fetched word into IF/ID.
//   clk, reset (sync, active high)
//   stall_i, flush_i, redirect_i/redirect_pc_i, irq_i, exc_i : next-PC events
//   rom_addr_o / rom_data_i / rom_ovf_i                       : instruction ROM
//   pc_o, ifid_valid_o, ifid_instr_o, ifid_pc4_o              : PC and IF/ID
//   irq_taken_o, epc_o                                        : vector entry, return PC
// Macro FETCH_OVF_EXC_EN: treat ROM overflow as a fetch exception.
module if_fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_C,
  parameter logic [31:0] ILLOP_PC = ILLOP_PC_C,
  parameter logic [31:0] XADR_PC  = XADR_PC_C
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        irq_i,
  input  logic        exc_i,
  output logic [30:0] rom_addr_o,
  input  logic [31:0] rom_data_i,
  input  logic        rom_ovf_i,
  output logic [31:0] pc_o,
  output logic        ifid_valid_o,
  output logic [31:0] ifid_instr_o,
  output logic [31:0] ifid_pc4_o,
  output logic        irq_taken_o,
  output logic [31:0] epc_o
);
  logic [31:0] pc_q, pc_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc4_q, ifid_pc4_d;
  logic        irq_taken_q, irq_taken_d;
  logic [31:0] epc_q, epc_d;

  logic [31:0] next_pc, pc4;
  logic        ifid_bubble, ifid_hold, vector_taken;

  assign pc4 = pc_plus4(pc_q);

  fetch_pc_sel #(.ILLOP_PC(ILLOP_PC), .XADR_PC(XADR_PC)) u_pc_sel (
    .pc_q          (pc_q),
    .exc_i         (exc_i),
    .irq_i         (irq_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .stall_i       (stall_i),
    .flush_i       (flush_i),
    .rom_ovf_i     (rom_ovf_i),
    .next_pc       (next_pc),
    .ifid_bubble   (ifid_bubble),
    .ifid_hold     (ifid_hold),
    .vector_taken  (vector_taken)
  );

  always_comb begin
    pc_d         = next_pc;
    ifid_valid_d = 1'b1;
    ifid_instr_d = rom_data_i;
    ifid_pc4_d   = pc4;
    irq_taken_d  = vector_taken;
    // The victim at pc_q never issues, so the handler returns to pc_q via $k0-4.
    epc_d        = vector_taken ? pc4 : epc_q;
    if (ifid_bubble) begin
      // Bubbles leave pc4 alone so a stale link value is never mistaken for a new one.
      ifid_valid_d = 1'b0;
      ifid_instr_d = NOP_INSTR;
      ifid_pc4_d   = ifid_pc4_q;
    end else if (ifid_hold) begin
      ifid_valid_d = ifid_valid_q;
      ifid_instr_d = ifid_instr_q;
      ifid_pc4_d   = ifid_pc4_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q         <= RESET_PC;
      ifid_valid_q <= 1'b0;
      ifid_instr_q <= NOP_INSTR;
      ifid_pc4_q   <= 32'h0;
      irq_taken_q  <= 1'b0;
      epc_q        <= 32'h0;
    end else begin
      pc_q         <= pc_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc4_q   <= ifid_pc4_d;
      irq_taken_q  <= irq_taken_d;
      epc_q        <= epc_d;
    end
  end

  assign rom_addr_o   = pc_q[30:0];
  assign pc_o         = pc_q;
  assign ifid_valid_o = ifid_valid_q;
  assign ifid_instr_o = ifid_instr_q;
  assign ifid_pc4_o   = ifid_pc4_q;
  assign irq_taken_o  = irq_taken_q;
  assign epc_o        = epc_q;
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: directed table of single-cycle vectors applied from reset,
// followed by hand-written reset/kernel-mode corner sequences.
// The ROM model returns {8'hEE, addr[23:0]}, or 0 while rom_ovf_i is driven.
module tb_if_fetch_stage;
  logic        clk = 1'b0;
  logic        reset, stall_i, flush_i, redirect_i, irq_i, exc_i, rom_ovf_i;
  logic [31:0] redirect_pc_i, rom_data_i;
  logic [30:0] rom_addr_o;
  logic [31:0] pc_o, ifid_instr_o, ifid_pc4_o, epc_o;
  logic        ifid_valid_o, irq_taken_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign rom_data_i = rom_ovf_i ? 32'h0 : {8'hEE, rom_addr_o[23:0]};

  if_fetch_stage dut (
    .clk(clk), .reset(reset), .stall_i(stall_i), .flush_i(flush_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i), .irq_i(irq_i),
    .exc_i(exc_i), .rom_addr_o(rom_addr_o), .rom_data_i(rom_data_i),
    .rom_ovf_i(rom_ovf_i), .pc_o(pc_o), .ifid_valid_o(ifid_valid_o),
    .ifid_instr_o(ifid_instr_o), .ifid_pc4_o(ifid_pc4_o),
    .irq_taken_o(irq_taken_o), .epc_o(epc_o)
  );

  typedef struct {
    logic        stall, flush, redir;
    logic [31:0] rpc;
    logic        irq, exc, ovf;
    logic [31:0] pc;
    logic        vld;
    logic [31:0] instr, pc4;
    logic        tk;
    logic [31:0] epc;
  } vec_t;

`ifdef FETCH_OVF_EXC_EN
  localparam logic [31:0] OV_PC = 32'h8000_0008, OV_PC4 = 32'h8000_00B8, OV_EPC = 32'h284;
  localparam logic        OV_VLD = 1'b0, OV_TK = 1'b1;
  localparam logic [31:0] K_PC = 32'h8000_02A0;
  localparam logic        K_VLD = 1'b0;
  localparam logic [31:0] K_PC4 = 32'h0;
`else
  localparam logic [31:0] OV_PC = 32'h284, OV_PC4 = 32'h284, OV_EPC = 32'h24;
  localparam logic        OV_VLD = 1'b1, OV_TK = 1'b0;
  localparam logic [31:0] K_PC = 32'h8000_02A4;
  localparam logic        K_VLD = 1'b1;
  localparam logic [31:0] K_PC4 = 32'h8000_02A4;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic fl, input logic rd, input logic [31:0] rp,
                       input logic iq, input logic ex, input logic ov);
    stall_i = st; flush_i = fl; redirect_i = rd; redirect_pc_i = rp;
    irq_i = iq; exc_i = ex; rom_ovf_i = ov;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[17];

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 32'h0, 0, 0, 0);
    //            st fl rd rpc           iq ex ov  pc            vld instr          pc4           tk epc
    vecs[0]  = '{0, 0, 0, 32'h0,        0, 0, 0, 32'h8000_0004, 1, 32'hEE00_0000, 32'h8000_0004, 0, 32'h0};
    vecs[1]  = '{0, 0, 0, 32'h0,        0, 0, 0, 32'h8000_0008, 1, 32'hEE00_0004, 32'h8000_0008, 0, 32'h0};
    vecs[2]  = '{1, 0, 0, 32'h0,        0, 0, 0, 32'h8000_0008, 1, 32'hEE00_0004, 32'h8000_0008, 0, 32'h0};
    vecs[3]  = '{1, 1, 0, 32'h0,        0, 0, 0, 32'h8000_0008, 0, 32'h0,         32'h8000_0008, 0, 32'h0};
    vecs[4]  = '{1, 0, 1, 32'h53,       0, 0, 0, 32'h50,        0, 32'h0,         32'h8000_0008, 0, 32'h0};
    vecs[5]  = '{0, 1, 0, 32'h0,        0, 0, 0, 32'h54,        0, 32'h0,         32'h8000_0008, 0, 32'h0};
    vecs[6]  = '{0, 0, 1, 32'h100,      0, 0, 0, 32'h100,       0, 32'h0,         32'h8000_0008, 0, 32'h0};
    vecs[7]  = '{0, 0, 0, 32'h0,        1, 0, 0, 32'h8000_0004, 0, 32'h0,         32'h8000_0008, 1, 32'h104};
    vecs[8]  = '{0, 0, 0, 32'h0,        0, 0, 0, 32'h8000_0008, 1, 32'hEE00_0004, 32'h8000_0008, 0, 32'h104};
    vecs[9]  = '{0, 0, 1, 32'h8000_00B4, 0, 0, 0, 32'h8000_00B4, 0, 32'h0,        32'h8000_0008, 0, 32'h104};
    vecs[10] = '{0, 0, 0, 32'h0,        1, 0, 0, 32'h8000_00B8, 1, 32'hEE00_00B4, 32'h8000_00B8, 0, 32'h104};
    vecs[11] = '{0, 0, 1, 32'h20,       0, 0, 0, 32'h20,        0, 32'h0,         32'h8000_00B8, 0, 32'h104};
    vecs[12] = '{0, 0, 0, 32'h0,        1, 1, 0, 32'h8000_0008, 0, 32'h0,         32'h8000_00B8, 1, 32'h24};
    vecs[13] = '{0, 0, 1, 32'h280,      0, 0, 0, 32'h280,       0, 32'h0,         32'h8000_00B8, 0, 32'h24};
    vecs[14] = '{0, 0, 0, 32'h0,        0, 0, 1, OV_PC,         OV_VLD, 32'h0,    OV_PC4,        OV_TK, OV_EPC};
    vecs[15] = '{0, 0, 1, 32'h7FFF_FFFC, 0, 0, 0, 32'h7FFF_FFFC, 0, 32'h0,        OV_PC4,        0, OV_EPC};
    vecs[16] = '{0, 0, 0, 32'h0,        0, 0, 0, 32'h0,         1, 32'hEEFF_FFFC, 32'h0,         0, OV_EPC};

    step; step;
    chk("rst_pc", pc_o, 32'h8000_0000);
    chk("rst_addr", {1'b0, rom_addr_o}, 32'h0);
    chk("rst_vld", {31'h0, ifid_valid_o}, 32'h0);
    chk("rst_instr", ifid_instr_o, 32'h0);
    chk("rst_pc4", ifid_pc4_o, 32'h0);
    chk("rst_tk", {31'h0, irq_taken_o}, 32'h0);
    chk("rst_epc", epc_o, 32'h0);

    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].stall, vecs[i].flush, vecs[i].redir, vecs[i].rpc,
            vecs[i].irq, vecs[i].exc, vecs[i].ovf);
      step;
      chk($sformatf("v%0d_pc", i), pc_o, vecs[i].pc);
      chk($sformatf("v%0d_vld", i), {31'h0, ifid_valid_o}, {31'h0, vecs[i].vld});
      chk($sformatf("v%0d_instr", i), ifid_instr_o, vecs[i].instr);
      chk($sformatf("v%0d_pc4", i), ifid_pc4_o, vecs[i].pc4);
      chk($sformatf("v%0d_tk", i), {31'h0, irq_taken_o}, {31'h0, vecs[i].tk});
      chk($sformatf("v%0d_epc", i), epc_o, vecs[i].epc);
      @(negedge clk);
    end

    // Reset during a stall wins the edge.
    drive(1, 0, 0, 32'h0, 0, 0, 0);
    reset = 1'b1;
    step;
    chk("rst_stall_pc", pc_o, 32'h8000_0000);
    chk("rst_stall_vld", {31'h0, ifid_valid_o}, 32'h0);
    chk("rst_stall_pc4", ifid_pc4_o, 32'h0);
    chk("rst_stall_epc", epc_o, 32'h0);

    // Reset during vector entry (user-mode irq and exc pending) wins too.
    @(negedge clk);
    reset = 1'b0;
    drive(0, 0, 1, 32'h40, 0, 0, 0);
    step;
    chk("pre_vec_pc", pc_o, 32'h40);
    @(negedge clk);
    drive(0, 0, 0, 32'h0, 1, 1, 0);
    reset = 1'b1;
    step;
    chk("rst_vec_pc", pc_o, 32'h8000_0000);
    chk("rst_vec_tk", {31'h0, irq_taken_o}, 32'h0);
    chk("rst_vec_epc", epc_o, 32'h0);

    // Kernel-mode ROM overflow: parks on the same PC when enabled.
    @(negedge clk);
    reset = 1'b0;
    drive(0, 0, 1, 32'h8000_02A0, 0, 0, 0);
    step;
    @(negedge clk);
    drive(0, 0, 0, 32'h0, 0, 0, 1);
    step;
    chk("kovf_pc", pc_o, K_PC);
    chk("kovf_vld", {31'h0, ifid_valid_o}, {31'h0, K_VLD});
    chk("kovf_instr", ifid_instr_o, 32'h0);
    chk("kovf_pc4", ifid_pc4_o, K_PC4);
    chk("kovf_tk", {31'h0, irq_taken_o}, 32'h0);

    // Kernel-mode wrap keeps the supervisor bit.
    @(negedge clk);
    drive(0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0);
    step;
    @(negedge clk);
    drive(0, 0, 0, 32'h0, 0, 0, 0);
    step;
    chk("kwrap_pc", pc_o, 32'h8000_0000);
    chk("kwrap_pc4", ifid_pc4_o, 32'h8000_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
